// File: rtl/axi_burst_slave_mem.sv
// AXI4 slave memory: single-ID INCR bursts, one outstanding per direction.
// Ports: aclk/areset, AW/W/B write channels, AR/R read channels.
module axi_burst_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [2:0] SIZE   = 3'(OFF);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  w_state_t   w_st;
  logic [IDX_W-1:0] w_idx;
  logic [7:0] w_cnt;
  logic       w_err;

  r_state_t   r_st;
  logic [IDX_W-1:0] r_idx;
  logic [7:0] r_cnt;
  logic       r_err;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic aw_err, ar_err, w_fire, w_mis;

  assign aw_idx = s_axi_awaddr[IDX_W+OFF-1:OFF];
  assign ar_idx = s_axi_araddr[IDX_W+OFF-1:OFF];
  assign aw_err = (s_axi_awburst != INCR) | (s_axi_awsize != SIZE);
  assign ar_err = (s_axi_arburst != INCR) | (s_axi_arsize != SIZE);
  assign w_fire = (w_st == W_DATA) & s_axi_wvalid & s_axi_wready;
  assign w_mis  = s_axi_wlast != (w_cnt == 8'd0);

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[ADDR_W-1:IDX_W+OFF],
                       s_axi_awaddr[OFF-1:0],
                       s_axi_araddr[ADDR_W-1:IDX_W+OFF],
                       s_axi_araddr[OFF-1:0]};

  // Byte-enabled write port; a beat landing in the reset cycle is dropped.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_err && !areset) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_st          <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      w_idx         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_st)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_idx         <= aw_idx;
            w_cnt         <= s_axi_awlen;
            w_err         <= aw_err;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_st          <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt - 8'd1;
            if (w_mis) w_err <= 1'b1;
            if (w_cnt == 8'd0) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err | w_mis) ? SLVERR : 2'b00;
              w_st         <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_st          <= W_IDLE;
          end
        end
        default: w_st <= W_IDLE;
      endcase
    end
  end

  // rdata is fetched straight from the RAM on the AR handshake and on
  // every accepted beat, so the next word is ready with no bubble.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_st          <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_st)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_err         <= ar_err;
            s_axi_rdata   <= ar_err ? '0 : mem[ar_idx];
            s_axi_rresp   <= ar_err ? SLVERR : 2'b00;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_idx         <= ar_idx + 1'b1;
            r_cnt         <= s_axi_arlen;
            r_st          <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_st          <= R_IDLE;
            end else begin
              s_axi_rdata <= r_err ? '0 : mem[r_idx];
              s_axi_rlast <= (r_cnt == 8'd1);
              r_idx       <= r_idx + 1'b1;
              r_cnt       <= r_cnt - 8'd1;
            end
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Self-checking bench for axi_burst_slave_mem.
// Random and directed bursts checked against a word-array reference memory.
module tb_axi_burst_slave_mem;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [1024];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  axi_burst_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat);
    return int'(((addr >> 3) + 32'(beat)) & 32'h3ff);
  endfunction

  function automatic void model_write(input logic [31:0] addr,
                                      input int nbeats);
    for (int i = 0; i < nbeats; i++)
      for (int b = 0; b < 8; b++)
        if (ws[i][b])
          ref_mem[widx(addr, i)][b*8 +: 8] = wd[i][b*8 +: 8];
  endfunction

  // All tasks are entered and left on a falling edge.
  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int bad_last, input bit gaps);
    int n;
    bit err;
    err = (burst != 2'b01) || (size != 3'd3) || (bad_last >= 0);
    awaddr = addr; awlen = 8'(len);
    awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) check("aw_timeout", 0, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        wvalid = 1'b0;
        @(negedge aclk);
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
      n = 0;
      while (!wready && n < 100) begin @(negedge aclk); n++; end
      if (n >= 100) check("w_timeout", 0, 1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_done", wready, 0);
    check("bvalid_lat", bvalid, 1);
    if (gaps) begin
      bready = 1'b0;
      @(negedge aclk);
      check("bvalid_hold", bvalid, 1);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge aclk); n++; end
    check("bresp", bresp, err ? 64'd2 : 64'd0);
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_clr", bvalid, 0);
    check("awready_back", awready, 1);
    if (!err) model_write(addr, len + 1);
  endtask

  // mode 0: rready high, 1: toggling, 2: random
  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input int mode);
    int n, beat;
    bit err;
    logic [63:0] ed;
    err = (burst != 2'b01) || (size != 3'd3);
    araddr = addr; arlen = 8'(len);
    arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) check("ar_timeout", 0, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_lat", rvalid, 1);
    beat = 0; n = 0;
    while (beat <= len && n < 3000) begin
      rready = (mode == 0) ? 1'b1 :
               (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(1));
      if (mode == 0) check("rvalid_b2b", rvalid, 1);
      if (rvalid) begin
        ed = err ? 64'd0 : ref_mem[widx(addr, beat)];
        check("rdata", rdata, ed);
        check("rresp", rresp, err ? 64'd2 : 64'd0);
        check("rlast", rlast, beat == len);
        if (rready) beat++;
      end
      @(negedge aclk);
      n++;
    end
    rready = 1'b0;
    if (beat <= len) check("r_timeout", 0, 1);
    check("rvalid_end", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  initial begin
    logic [31:0] a;
    int n, len;
    areset = 1'b1;
    awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 0;
    rready = 0;
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    areset = 1'b0;
    @(negedge aclk);

    // fill the whole RAM with 256-beat bursts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = 8'hFF;
      end
      do_write(32'(k * 2048), 255, 2'b01, 3'd3, -1, k == 0);
    end
    do_read(32'h0, 255, 2'b01, 3'd3, 2);

    // single write and read back
    wd[0] = 64'hF8F4F2F1; ws[0] = 8'hFF;
    do_write(32'h1000_0000, 0, 2'b01, 3'd3, -1, 0);
    do_read(32'h1000_0000, 0, 2'b01, 3'd3, 0);

    // 16 beats, toggling rready
    for (int i = 0; i < 16; i++) begin
      wd[i] = 64'(15 - i); ws[i] = 8'hFF;
    end
    do_write(32'h1000_0080, 15, 2'b01, 3'd3, -1, 0);
    do_read(32'h1000_0080, 15, 2'b01, 3'd3, 1);

    // partial strobes
    wd[0] = 64'h1111111122222222; ws[0] = 8'hFF;
    do_write(32'h3000_1500, 0, 2'b01, 3'd3, -1, 0);
    wd[0] = 64'hBADCAFEEBADCAFEE; ws[0] = 8'b00000001;
    do_write(32'h3000_1500, 0, 2'b01, 3'd3, -1, 0);
    do_read(32'h3000_1500, 0, 2'b01, 3'd3, 0);
    wd[0] = 64'h0; ws[0] = 8'hFF;
    do_write(32'h3000_1500, 0, 2'b01, 3'd3, -1, 0);
    wd[0] = 64'hDEADBEEFDEADBEEF; ws[0] = 8'b10101010;
    do_write(32'h3000_1500, 0, 2'b01, 3'd3, -1, 0);
    do_read(32'h3000_1500, 0, 2'b01, 3'd3, 0);

    // index wrap 1022 -> 1 and address alias
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
    end
    do_write(32'h1FF0, 3, 2'b01, 3'd3, -1, 1);
    do_read(32'h3FF0, 3, 2'b01, 3'd3, 1);
    do_read(32'h0, 1, 2'b01, 3'd3, 0);

    // FIXED burst: beats consumed, RAM untouched
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
    end
    do_write(32'h100, 3, 2'b00, 3'd3, -1, 0);
    do_read(32'h100, 3, 2'b01, 3'd3, 0);

    // early wlast, then a clean rewrite of the same words
    do_write(32'h200, 3, 2'b01, 3'd3, 1, 0);
    do_write(32'h200, 3, 2'b01, 3'd3, -1, 0);
    do_read(32'h200, 3, 2'b01, 3'd3, 2);

    // bad arsize
    do_read(32'h200, 3, 2'b01, 3'd2, 0);

    // reset during beat 5 of a 16-beat write
    for (int i = 0; i < 16; i++) begin
      wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
    end
    awaddr = 32'h400; awlen = 8'd15; awburst = 2'b01; awsize = 3'd3;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wready_pre_rst", wready, 1);
      wvalid = 1'b1; wdata = wd[i]; wstrb = 8'hFF; wlast = 1'b0;
      @(negedge aclk);
    end
    model_write(32'h400, 4);
    wdata = wd[4]; wvalid = 1'b1; areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0; wvalid = 1'b0;
    check("mid_rst_awready", awready, 1);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    do_write(32'h400, 0, 2'b01, 3'd3, -1, 0);
    do_read(32'h400, 15, 2'b01, 3'd3, 0);

    // random traffic
    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      len = $urandom_range(0, 20);
      for (int i = 0; i <= len; i++) begin
        wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom);
      end
      do_write(a, len, 2'b01, 3'd3, -1, 1);
      if ($urandom_range(4) == 0)
        do_read(a, len, 2'($urandom_range(2)), 3'($urandom_range(7)),
                $urandom_range(2));
      else
        do_read(a, len, 2'b01, 3'd3, $urandom_range(2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
